// File: rtl/commit_out_unit_pkg.sv
// Shared definitions for the OUT-commit UART path: byte width, default sizes
// and the transmitter state encoding.
package commit_out_unit_pkg;

    localparam int DATA_W                 = 8;
    localparam int DEFAULT_OUT_FIFO_WIDTH = 4;
    localparam int UART_CLK_PER_BIT       = 868;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/commit_out_unit_uart_tx.sv
// 8N1 UART transmitter. Takes a byte whenever start is offered while idle or at
// the end of a stop bit, so queued bytes go out back-to-back without idle gaps.
module uart_tx
    import commit_out_unit_pkg::*;
#(
    parameter int CLK_PER_BIT = UART_CLK_PER_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              done,
    output logic              busy,
    output logic              txd
);

    localparam int                BAUD_W    = $clog2(CLK_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
    localparam int                BIT_W     = $clog2(DATA_W);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    tx_state_t         state, state_n;
    logic [BAUD_W-1:0] baud_cnt, baud_n;
    logic [BIT_W-1:0]  bit_cnt, bit_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic              txd_n;
    logic              baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign busy     = (state != IDLE);

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        txd_n   = txd;
        done    = 1'b0;
        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (start) begin
                    done    = 1'b1;
                    shift_n = data;
                    bit_n   = '0;
                    baud_n  = '0;
                    txd_n   = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_n  = '0;
                    txd_n   = shift[0];
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (bit_cnt == BIT_LAST) begin
                        txd_n   = 1'b1;
                        state_n = STOP;
                    end else begin
                        shift_n = {1'b0, shift[DATA_W-1:1]};
                        txd_n   = shift[1];
                        bit_n   = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_n = '0;
                    // Chain straight into the next start bit when more bytes wait.
                    if (start) begin
                        done    = 1'b1;
                        shift_n = data;
                        bit_n   = '0;
                        txd_n   = 1'b0;
                        state_n = START;
                    end else begin
                        txd_n   = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: begin
                txd_n   = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            txd      <= txd_n;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_n;
    end

endmodule

// File: rtl/commit_out_unit.sv
// OUT commit consumer: queues committed bytes in an in-order FIFO and drains
// them onto the UART. Ready depends only on registered pointers.
module commit_out_unit
    import commit_out_unit_pkg::*;
#(
    parameter int OUT_FIFO_WIDTH = DEFAULT_OUT_FIFO_WIDTH,
    parameter int CLK_PER_BIT    = UART_CLK_PER_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commit_out_valid,
    output logic              commit_out_ready,
    input  logic [DATA_W-1:0] commit_out_data,
    output logic              txd,
    output logic              tx_busy
);

    localparam int DEPTH = 1 << OUT_FIFO_WIDTH;

    logic [DATA_W-1:0]       mem [DEPTH];
    logic [OUT_FIFO_WIDTH:0] wr_ptr, rd_ptr;
    logic                    full, empty, push, pop, have_data, uart_busy;

    // The extra pointer bit tells a full FIFO apart from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[OUT_FIFO_WIDTH] != rd_ptr[OUT_FIFO_WIDTH]) &&
                   (wr_ptr[OUT_FIFO_WIDTH-1:0] == rd_ptr[OUT_FIFO_WIDTH-1:0]);

    assign commit_out_ready = !full;
    assign push             = commit_out_valid && !full;
    assign have_data        = !empty;
    assign tx_busy          = have_data || uart_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[OUT_FIFO_WIDTH-1:0]] <= commit_out_data;
    end

    uart_tx #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .reset (reset),
        .start (have_data),
        .data  (mem[rd_ptr[OUT_FIFO_WIDTH-1:0]]),
        .done  (pop),
        .busy  (uart_busy),
        .txd   (txd)
    );

endmodule

// File: tb/tb_commit_out_unit.sv
// Bench for commit_out_unit with a 4-entry FIFO and 4 clocks per UART bit.
module tb_commit_out_unit;

    localparam int FW    = 2;
    localparam int CPB   = 4;
    localparam int DEPTH = 1 << FW;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       commit_out_valid = 1'b0;
    logic [7:0] commit_out_data = 8'h00;
    logic       commit_out_ready;
    logic       txd;
    logic       tx_busy;

    commit_out_unit #(
        .OUT_FIFO_WIDTH(FW),
        .CLK_PER_BIT   (CPB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .commit_out_valid(commit_out_valid),
        .commit_out_ready(commit_out_ready),
        .commit_out_data (commit_out_data),
        .txd             (txd),
        .tx_busy         (tx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: a queue of waiting bytes plus one frame in flight, timed by
    // the number of clocks since that frame's start bit began.
    logic [7:0] m_q[$];
    logic       m_fly = 1'b0;
    int         m_fk = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_acc = 1'b0;
    logic       m_room;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_fly = 1'b0;
            m_fk  = 0;
            m_acc = 1'b0;
        end else begin
            m_room = (m_q.size() < DEPTH);
            m_acc  = commit_out_valid && m_room;
            if (m_fly) begin
                m_fk++;
                if (m_fk == FRAME) m_fly = 1'b0;
            end
            if (!m_fly && m_q.size() != 0) begin
                m_byte = m_q.pop_front();
                m_fly  = 1'b1;
                m_fk   = 0;
            end
            if (m_acc) m_q.push_back(commit_out_data);
        end
    end

    function automatic logic exp_txd();
        int k;
        if (!m_fly) return 1'b1;
        k = m_fk / CPB;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("model_txd", txd, exp_txd());
        check("model_ready", commit_out_ready, m_q.size() < DEPTH);
        check("model_busy", tx_busy, (m_q.size() != 0) || m_fly);
    end

    task automatic at_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_fly || m_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout at cycle %0d: still busy after %0d cycles, required idle", cyc, budget);
        end
    endtask

    task automatic stream(input logic [7:0] base, input int count);
        for (int i = 0; i < count; i++) begin
            int n = 0;
            commit_out_valid = 1'b1;
            commit_out_data  = 8'(base + i);
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!m_acc && n < 400);
            if (n >= 400) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout at cycle %0d: byte %0h not accepted, required acceptance", cyc, commit_out_data);
            end
        end
        commit_out_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // expected txd per bit slot, slot 0 = start bit
    } vec_t;

    vec_t vecs[5];
    int   e;

    initial begin
        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'h81, 10'b1100000010};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_txd", txd, 1'b1);
        check("reset_ready", commit_out_ready, 1'b1);
        check("reset_busy", tx_busy, 1'b0);

        // Single frames; the first byte is accepted exactly at edge 10.
        for (int v = 0; v < 5; v++) begin
            if (v == 0) at_cycle(9);
            else begin
                wait_idle(200);
                @(negedge clk);
            end
            e = cyc + 1;
            commit_out_valid = 1'b1;
            commit_out_data  = vecs[v].data;
            @(posedge clk);
            #1 commit_out_valid = 1'b0;
            for (int b = 0; b < 10; b++) begin
                at_cycle(e + 2 + CPB * b);
                check("frame_bit", txd, vecs[v].frame[b]);
            end
            at_cycle(e + FRAME);
            check("busy_last_stop", tx_busy, 1'b1);
            at_cycle(e + FRAME + 1);
            check("busy_after_frame", tx_busy, 1'b0);
        end

        // Back-to-back frames with no idle gap.
        wait_idle(200);
        @(negedge clk);
        e = cyc + 1;
        stream(8'h00, 1);
        stream(8'hFF, 1);
        at_cycle(e + FRAME);
        check("b2b_stop1", txd, 1'b1);
        at_cycle(e + FRAME + 1);
        check("b2b_start2", txd, 1'b0);
        at_cycle(e + FRAME + 5);
        check("b2b_data2", txd, 1'b1);
        at_cycle(e + 2 * FRAME + 1);
        check("b2b_idle", tx_busy, 1'b0);

        // Six commits against a busy transmitter; full and pop coincide.
        wait_idle(200);
        @(negedge clk);
        e = cyc + 1;
        fork
            stream(8'h40, 6);
            begin
                at_cycle(e + 4);
                check("six_full", commit_out_ready, 1'b0);
                at_cycle(e + FRAME);
                check("full_before_pop", commit_out_ready, 1'b0);
                at_cycle(e + FRAME + 1);
                check("room_after_pop", commit_out_ready, 1'b1);
                at_cycle(e + FRAME + 2);
                check("refull_after_sixth", commit_out_ready, 1'b0);
            end
        join
        wait_idle(7 * FRAME);

        // Pointer wrap-around: twenty bytes streamed with valid held high.
        stream(8'h00, 20);
        wait_idle(22 * FRAME);
        @(negedge clk);
        check("wrap_idle", tx_busy, 1'b0);

        // Reset in the middle of a data bit with two bytes queued.
        @(negedge clk);
        e = cyc + 1;
        stream(8'h3C, 1);
        stream(8'h11, 1);
        stream(8'h22, 1);
        at_cycle(e + 12);
        #1 reset = 1'b1;
        #1;
        check("rst_async_txd", txd, 1'b1);
        check("rst_async_ready", commit_out_ready, 1'b1);
        check("rst_async_busy", tx_busy, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3 * FRAME) @(negedge clk);
        check("no_frame_after_rst_txd", txd, 1'b1);
        check("no_frame_after_rst_busy", tx_busy, 1'b0);

        // Random traffic: a dense phase then a sparse phase.
        for (int phase = 0; phase < 2; phase++) begin
            repeat (1500) begin
                @(posedge clk);
                #1;
                commit_out_valid = (phase == 0) ? ($urandom_range(0, 3) != 0)
                                                : ($urandom_range(0, 40) == 0);
                commit_out_data  = 8'($urandom);
            end
            commit_out_valid = 1'b0;
            wait_idle((DEPTH + 2) * FRAME);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
